result_checker: RTL and testbench

RESULT_CHECKER -- requirements
Module: result_checker

---
 rtl/result_checker_pkg.sv | 18 +
 rtl/result_checker_popcount.sv | 21 ++
 rtl/result_checker.sv | 183 ++++++++++++++++++
 tb/tb_result_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_checker_pkg.sv
// rtl/result_checker_pkg.sv - shared FSM state encoding and default widths for result_checker
package result_checker_pkg;

    // Default width of one captured result word.
    localparam int DEFAULT_DATA_WL = 16;

    // Default capture-BRAM address width; one run covers 2^DEFAULT_ADDR_WL words.
    localparam int DEFAULT_ADDR_WL = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_CHECK = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/result_checker_popcount.sv
// rtl/result_checker_popcount.sv - combinational count of set bits in one word
//
// Ports:
//   data  : word whose set bits are counted
//   count : number of bits set in data
module popcount #(
    parameter int DataWL = 16,
    parameter int CntWL  = $clog2(DataWL + 1)
) (
    input  logic [DataWL-1:0] data,
    output logic [CntWL-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < DataWL; i++) begin
            count = count + CntWL'(data[i]);
        end
    end

endmodule

// File: rtl/result_checker.sv
// rtl/result_checker.sv - compares a capture-BRAM readback burst against golden ROM data
//
// Ports:
//   clk, nrst        : clock, asynchronous active-low reset
//   start            : one-cycle request to arm a check of the next readback burst
//   read_enable      : tells the readback controller it may start its burst (ARM only)
//   bram_read_en     : controller read strobe, address valid this cycle
//   bram_read_finish : controller flag on the last address of the burst
//   bram_dout        : capture-BRAM data, one cycle after bram_read_en
//   golden_dout      : golden ROM data, same latency as bram_dout
//   busy             : high in ARM, CHECK and FLUSH
//   done             : high in DONE; result outputs are stable while high
//   word_errs        : saturating count of mismatching words
//   bit_errs         : saturating count of differing bits
//   first_err_addr   : word index of the first mismatch, 0 if none
//   err_seen         : sticky flag, set on the first mismatch of the run
module result_checker
    import result_checker_pkg::*;
#(
    parameter int DataWL = DEFAULT_DATA_WL,
    parameter int AddrWL = DEFAULT_ADDR_WL
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                start,
    output logic                                read_enable,
    input  logic                                bram_read_en,
    input  logic                                bram_read_finish,
    input  logic [DataWL-1:0]                   bram_dout,
    input  logic [DataWL-1:0]                   golden_dout,
    output logic                                busy,
    output logic                                done,
    output logic [AddrWL:0]                     word_errs,
    output logic [AddrWL+$clog2(DataWL):0]      bit_errs,
    output logic [AddrWL-1:0]                   first_err_addr,
    output logic                                err_seen
);

    localparam int BitWL = AddrWL + $clog2(DataWL) + 1;
    localparam int CntWL = $clog2(DataWL + 1);

    state_t state;
    state_t state_n;

    logic              valid1;
    logic              last1;
    logic              valid2;
    logic              last2;
    logic [DataWL-1:0] diff;
    logic [AddrWL-1:0] word_idx;
    logic [CntWL-1:0]  diff_ones;

    logic              capture;
    logic              arm_entry;
    logic [AddrWL+1:0] word_sum;
    logic [AddrWL:0]   word_next;
    logic [BitWL:0]    bit_sum;
    logic [BitWL-1:0]  bit_next;

    popcount #(
        .DataWL (DataWL),
        .CntWL  (CntWL)
    ) u_popcount (
        .data  (diff),
        .count (diff_ones)
    );

    // Strobes are only accepted while a run is armed or being checked, so
    // controller traffic in IDLE, FLUSH or DONE never reaches the counters.
    assign capture   = (state == ST_ARM) || (state == ST_CHECK);
    assign arm_entry = (state_n == ST_ARM) && (state != ST_ARM);

    // Saturating increments: one extra carry bit detects overflow, which
    // then pins the counter at all-ones.
    always_comb begin
        word_sum  = {1'b0, word_errs} + (AddrWL + 2)'(1);
        word_next = word_sum[AddrWL+1] ? '1 : word_sum[AddrWL:0];
        bit_sum   = {1'b0, bit_errs} + (BitWL + 1)'(diff_ones);
        bit_next  = bit_sum[BitWL] ? '1 : bit_sum[BitWL-1:0];
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_ARM;
                end
            end
            ST_ARM: begin
                // A one-word burst can carry finish on its first strobe.
                if (bram_read_en) begin
                    state_n = bram_read_finish ? ST_FLUSH : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bram_read_finish) begin
                    state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // last2 is consumed by stage 3 on this edge, so the final
                // word is already in the counters when DONE is entered.
                if (last2) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_n = ST_ARM;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and the registered status outputs, decoded from the next state
    // so they line up with the state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            read_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            read_enable <= (state_n == ST_ARM);
            busy        <= (state_n == ST_ARM) || (state_n == ST_CHECK) || (state_n == ST_FLUSH);
            done        <= (state_n == ST_DONE);
        end
    end

    // Stages 1 and 2: align strobe/finish with the read data, then latch
    // the XOR of capture and golden words.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid1 <= 1'b0;
            last1  <= 1'b0;
            valid2 <= 1'b0;
            last2  <= 1'b0;
            diff   <= '0;
        end else begin
            valid1 <= capture && bram_read_en;
            last1  <= capture && bram_read_finish;
            valid2 <= valid1;
            last2  <= last1;
            if (valid1) begin
                diff <= bram_dout ^ golden_dout;
            end
        end
    end

    // Stage 3: accumulate error statistics for each valid word.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_idx       <= '0;
            word_errs      <= '0;
            bit_errs       <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
        end else if (arm_entry) begin
            word_idx       <= '0;
            word_errs      <= '0;
            bit_errs       <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
        end else if (valid2) begin
            // Index wraps silently past 2^AddrWL-1.
            word_idx <= word_idx + AddrWL'(1);
            if (diff != '0) begin
                word_errs <= word_next;
                bit_errs  <= bit_next;
                if (!err_seen) begin
                    first_err_addr <= word_idx;
                    err_seen       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - self-checking bench for result_checker
module tb_result_checker;

    localparam int DW  = 16;
    localparam int AW  = 9;
    localparam int BW  = AW + $clog2(DW) + 1;
    localparam int RUN = 1 << AW;
    localparam int MAXW = 1024;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          read_enable;
    logic          bram_read_en = 1'b0;
    logic          bram_read_finish = 1'b0;
    logic [DW-1:0] bram_dout = '0;
    logic [DW-1:0] golden_dout = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   word_errs;
    logic [BW-1:0] bit_errs;
    logic [AW-1:0] first_err_addr;
    logic          err_seen;

    result_checker #(
        .DataWL (DW),
        .AddrWL (AW)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .start            (start),
        .read_enable      (read_enable),
        .bram_read_en     (bram_read_en),
        .bram_read_finish (bram_read_finish),
        .bram_dout        (bram_dout),
        .golden_dout      (golden_dout),
        .busy             (busy),
        .done             (done),
        .word_errs        (word_errs),
        .bit_errs         (bit_errs),
        .first_err_addr   (first_err_addr),
        .err_seen         (err_seen)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bram_mem [MAXW];
    logic [DW-1:0] gold_mem [MAXW];

    typedef struct {
        int n;
        int kind;
        int gap_mode;
        int ew;
        int eb;
        int ef;
        int es;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Golden data is random; the capture copy is golden with chosen words corrupted.
    function automatic void fill_pattern(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            gold_mem[i] = DW'($urandom);
            bram_mem[i] = gold_mem[i];
        end
        case (kind)
            1: begin
                bram_mem[5]   = gold_mem[5]   ^ 16'h0003;
                bram_mem[511] = gold_mem[511] ^ 16'h8000;
            end
            2: begin
                for (int i = 0; i < n; i++) bram_mem[i] = ~gold_mem[i];
            end
            3: begin
                bram_mem[10]  = gold_mem[10]  ^ 16'h0001;
                bram_mem[100] = gold_mem[100] ^ 16'h0F00;
                bram_mem[400] = gold_mem[400] ^ 16'hFFFF;
            end
            4: bram_mem[515] = gold_mem[515] ^ 16'h0010;
            5: bram_mem[0]   = gold_mem[0]   ^ 16'h00FF;
            6: begin
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        bram_mem[i] = gold_mem[i] ^ DW'($urandom_range(1, 65535));
                    end
                end
            end
            default: ;
        endcase
    endfunction

    // Reference: walk the strobed words in order and tally mismatches.
    function automatic void model(input int n, output int w, output int b, output int f, output int s);
        logic [DW-1:0] d;
        w = 0; b = 0; f = 0; s = 0;
        for (int i = 0; i < n; i++) begin
            d = bram_mem[i] ^ gold_mem[i];
            if (d != 0) begin
                w++;
                b += $countones(d);
                if (s == 0) begin
                    f = i % RUN;
                    s = 1;
                end
            end
        end
        if (w > (1 << (AW + 1)) - 1) w = (1 << (AW + 1)) - 1;
        if (b > (1 << BW) - 1) b = (1 << BW) - 1;
    endfunction

    // Arms a run, plays the burst like the readback controller, then checks results.
    // gap_mode: 0 back-to-back, 1 strobe every other cycle, 2 random gaps.
    // abort_at >= 0 pulses nrst when that word is reached and returns.
    task automatic run_burst(input string tag, input int n, input int gap_mode, input int abort_at,
                             input int ew, input int eb, input int ef, input int es);
        int  a;
        int  pa;
        int  step;
        int  fin_cyc;
        int  waited;
        bit  ps;
        bit  st;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s read_enable_armed", tag), 32'(read_enable), 1);
        chk($sformatf("%s busy_armed", tag), 32'(busy), 1);
        chk($sformatf("%s cleared_on_arm", tag), 32'(word_errs) + 32'(bit_errs) + 32'(err_seen) + 32'(first_err_addr), 0);
        a = 0; pa = 0; step = 0; ps = 1'b0; fin_cyc = 0;
        while (a < n || ps) begin
            if (a == abort_at) begin
                nrst = 1'b0;
                bram_read_en = 1'b0;
                bram_read_finish = 1'b0;
                #1;
                chk($sformatf("%s abort_outputs", tag),
                    32'(word_errs) + 32'(bit_errs) + 32'(first_err_addr) + 32'(err_seen)
                    + 32'(busy) + 32'(done) + 32'(read_enable), 0);
                @(negedge clk);
                nrst = 1'b1;
                repeat (4) @(negedge clk);
                chk($sformatf("%s idle_after_abort", tag), 32'(busy) + 32'(read_enable) + 32'(done), 0);
                return;
            end
            if (ps) begin
                bram_dout   = bram_mem[pa];
                golden_dout = gold_mem[pa];
            end
            case (gap_mode)
                1:       st = (a < n) && (step % 2 == 0);
                2:       st = (a < n) && ($urandom_range(0, 3) != 0);
                default: st = (a < n);
            endcase
            bram_read_en     = st;
            bram_read_finish = st && (a == n - 1);
            if (st) begin
                if (a == n - 1) fin_cyc = cyc;
                pa = a;
                a++;
            end
            ps = st;
            step++;
            @(negedge clk);
        end
        bram_read_en = 1'b0;
        bram_read_finish = 1'b0;
        waited = 0;
        while (!done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("%s done_latency", tag), done ? 32'(cyc - fin_cyc) : 32'hFFFF_FFFF, 3);
        chk($sformatf("%s busy_in_done", tag), 32'(busy), 0);
        chk($sformatf("%s word_errs", tag), 32'(word_errs), 32'(ew));
        chk($sformatf("%s bit_errs", tag), 32'(bit_errs), 32'(eb));
        chk($sformatf("%s first_err_addr", tag), 32'(first_err_addr), 32'(ef));
        chk($sformatf("%s err_seen", tag), 32'(err_seen), 32'(es));
    endtask

    initial begin
        int  w;
        int  b;
        int  f;
        int  s;
        int  n;
        bit  re_seen;

        vecs[0] = '{n: 512, kind: 0, gap_mode: 0, ew: 0,   eb: 0,    ef: 0,  es: 0};
        vecs[1] = '{n: 512, kind: 1, gap_mode: 0, ew: 2,   eb: 3,    ef: 5,  es: 1};
        vecs[2] = '{n: 512, kind: 2, gap_mode: 0, ew: 512, eb: 8192, ef: 0,  es: 1};
        vecs[3] = '{n: 512, kind: 3, gap_mode: 1, ew: 3,   eb: 21,   ef: 10, es: 1};
        vecs[4] = '{n: 520, kind: 4, gap_mode: 2, ew: 1,   eb: 1,    ef: 3,  es: 1};
        vecs[5] = '{n: 1,   kind: 5, gap_mode: 0, ew: 1,   eb: 8,    ef: 0,  es: 1};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'(word_errs) + 32'(bit_errs) + 32'(first_err_addr) + 32'(err_seen)
            + 32'(busy) + 32'(done) + 32'(read_enable), 0);
        nrst = 1'b1;

        // Controller strobing mismatching data while no start has been given.
        re_seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            bram_read_en     = (i % 3 != 2);
            bram_read_finish = (i == 20);
            bram_dout        = DW'($urandom);
            golden_dout      = ~bram_dout;
            if (read_enable) re_seen = 1'b1;
        end
        @(negedge clk);
        bram_read_en = 1'b0;
        bram_read_finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_read_enable", 32'(re_seen), 0);
        chk("idle_counters", 32'(word_errs) + 32'(bit_errs) + 32'(err_seen), 0);
        chk("idle_busy", 32'(busy) + 32'(done), 0);

        for (int v = 0; v < 6; v++) begin
            fill_pattern(vecs[v].kind, vecs[v].n);
            run_burst($sformatf("vec%0d", v), vecs[v].n, vecs[v].gap_mode, -1,
                      vecs[v].ew, vecs[v].eb, vecs[v].ef, vecs[v].es);
        end

        // Strobes arriving in DONE must not disturb the held results of vec5.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bram_read_en = 1'b1;
            bram_dout    = 16'h1234;
            golden_dout  = 16'hEDCB;
        end
        @(negedge clk);
        bram_read_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_hold_word_errs", 32'(word_errs), 1);
        chk("done_hold_bit_errs", 32'(bit_errs), 8);
        chk("done_hold_done", 32'(done), 1);

        // Reset pulsed mid-run, then a fresh run must count correctly.
        fill_pattern(2, 512);
        run_burst("abort", 512, 0, 200, 0, 0, 0, 0);
        fill_pattern(1, 512);
        run_burst("after_abort", 512, 0, -1, 2, 3, 5, 1);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 600);
            fill_pattern(6, n);
            model(n, w, b, f, s);
            run_burst($sformatf("rand%0d", r), n, $urandom_range(0, 2), -1, w, b, f, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
